// File: rtl/sha256_core.sv
// sha256_core: single-block SHA-256 compression, one round per clock; define SHA256_CHAIN_EN to add `first` for multi-block chaining.
// Latency 65 clocks start->done; start is ignored while busy and in the done cycle (no queuing), next block accepted the cycle after done.
module sha256_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [511:0] message,
`ifdef SHA256_CHAIN_EN
   input  logic         first,
`endif
   output logic         busy,
   output logic         done,
   output logic [255:0] digest
);

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] k_rom(input logic [5:0] t);
      logic [31:0] k;
      case (t)
         6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
         6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
         6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
         6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
         6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
         6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
         6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
         6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
         6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
         6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
         6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
         6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
         6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
         6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
         6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
         6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
         default: k = '0;
      endcase
      return k;
   endfunction

   state_t        state_q, state_d;
   logic [6:0]    cnt_q, cnt_d;
   logic [31:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
   logic [31:0]   a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
   logic [31:0]   w_q [16];
   logic [31:0]   w_d [16];
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [255:0]  digest_q, digest_d;
   logic [255:0]  init_hv, base_hv;
   logic [31:0]   t1, t2, a_nx, e_nx, w_new;

`ifdef SHA256_CHAIN_EN
   logic          first_q, first_d;

   // Chained blocks start from, and fold into, the previous digest.
   assign init_hv = first ? IV : digest_q;
   assign base_hv = first_q ? IV : digest_q;
`else
   assign init_hv = IV;
   assign base_hv = IV;
`endif

   assign t1    = h_q + bsig1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + k_rom(cnt_q[5:0]) + w_q[0];
   assign t2    = bsig0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
   assign a_nx  = t1 + t2;
   assign e_nx  = d_q + t1;
   // w_q[0] is always W[t]; the new tail word is W[t+16].
   assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
      e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
      w_d      = w_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      digest_d = digest_q;
`ifdef SHA256_CHAIN_EN
      first_d  = first_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               for (int i = 0; i < 16; i++) w_d[i] = message[511 - 32*i -: 32];
               {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = init_hv;
`ifdef SHA256_CHAIN_EN
               first_d = first;
`endif
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!cnt_q[6]) begin
               a_d = a_nx; b_d = a_q; c_d = b_q; d_d = c_q;
               e_d = e_nx; f_d = e_q; g_d = f_q; h_d = g_q;
               for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
               w_d[15] = w_new;
               cnt_d   = cnt_q + 7'd1;
               if (cnt_q == 7'd63) begin
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  digest_d = {base_hv[255:224] + a_nx, base_hv[223:192] + a_q,
                              base_hv[191:160] + b_q,  base_hv[159:128] + c_q,
                              base_hv[127:96]  + e_nx, base_hv[95:64]   + e_q,
                              base_hv[63:32]   + f_q,  base_hv[31:0]    + g_q};
               end
            end else begin
               // Done cycle: still in RUN so a start here is dropped.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
         e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         digest_q <= '0;
`ifdef SHA256_CHAIN_EN
         first_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
         e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
         for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
         busy_q   <= busy_d;
         done_q   <= done_d;
         digest_q <= digest_d;
`ifdef SHA256_CHAIN_EN
         first_q  <= first_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign digest = digest_q;

endmodule

// File: tb/tb_sha256_core.sv
// Bench for sha256_core: known-answer table, random blocks against an array-based SHA-256 model, and start/reset corner sequences.
module tb_sha256_core;

   localparam logic [255:0] IV_REF = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [511:0] message;
   logic         busy, done;
   logic [255:0] digest;
`ifdef SHA256_CHAIN_EN
   logic         first;
`endif

   int checks = 0;
   int errors = 0;

   sha256_core dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .message (message),
`ifdef SHA256_CHAIN_EN
      .first   (first),
`endif
      .busy    (busy),
      .done    (done),
      .digest  (digest)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straight textbook compression: full 64-entry schedule, working variables as an array.
   function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
      return r;
   endfunction

   function automatic logic [511:0] pad_str(input string s);
      logic [511:0] blk = '0;
      for (int i = 0; i < s.len(); i++) blk[511 - 8*i -: 8] = s[i];
      blk[511 - 8*s.len() -: 8] = 8'h80;
      blk[63:0] = 64'(s.len() * 8);
      return blk;
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom();
      return m;
   endfunction

   // Called and returns on a falling edge; returns in the first cycle a new start can be taken.
   task automatic run_block(input logic [511:0] m, output logic [255:0] dg, output int lat);
      message = m;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      dg = digest;
      @(negedge clk);
      chk("done_single_cycle", {255'd0, done}, 256'd0);
   endtask

   typedef struct {
      logic [511:0] msg;
      logic [255:0] exp;
   } vec_t;

   vec_t         vecs [3];
   logic [255:0] dg;
   logic [511:0] ma, mb;
   int           lat, pulses;
   string        ones;

   initial begin
      ones = "";
      for (int i = 0; i < 55; i++) ones = {ones, "1"};
      vecs[0].msg = pad_str(ones);
      vecs[0].exp = 256'h31f713cc_40a632a9_ce454b30_29b727e9_bb6d0eea_11460f1d_7818852c_2565b9cd;
      vecs[1].msg = pad_str("abc");
      vecs[1].exp = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
      vecs[2].msg = pad_str("");
      vecs[2].exp = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

      rst_n   = 1'b0;
      start   = 1'b0;
      message = '0;
`ifdef SHA256_CHAIN_EN
      first   = 1'b1;
`endif
      repeat (2) @(negedge clk);
      chk("reset_busy",   {255'd0, busy}, 256'd0);
      chk("reset_done",   {255'd0, done}, 256'd0);
      chk("reset_digest", digest, 256'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         run_block(vecs[i].msg, dg, lat);
         chk($sformatf("kat%0d_digest", i), dg, vecs[i].exp);
         chk($sformatf("kat%0d_latency", i), 256'(lat), 256'd65);
      end

      for (int i = 0; i < 6; i++) begin
         ma = rand_block();
         run_block(ma, dg, lat);
         chk($sformatf("rand%0d_digest", i), dg, ref_compress(IV_REF, ma));
      end

      // start mid-run with a different block must be dropped
      ma = rand_block();
      mb = rand_block();
      message = ma;
      start   = 1'b1;
      pulses  = 0;
      lat     = 0;
      dg      = '0;
      for (int c = 1; c <= 150; c++) begin
         @(negedge clk);
         if (c == 30) begin
            start   = 1'b1;
            message = mb;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               lat = c;
               dg  = digest;
            end
         end
      end
      chk("midrun_start_pulses",  256'(pulses), 256'd1);
      chk("midrun_start_latency", 256'(lat), 256'd65);
      chk("midrun_start_digest",  dg, ref_compress(IV_REF, ma));

      // start in the done cycle is dropped; start on the following cycle is taken
      ma = rand_block();
      mb = rand_block();
      message = ma;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("done_cycle_latency", 256'(lat), 256'd65);
      message = mb;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_cycle_start_ignored", {255'd0, busy}, 256'd0);
      chk("done_cycle_digest", digest, ref_compress(IV_REF, ma));
      run_block(mb, dg, lat);
      chk("next_cycle_start_latency", 256'(lat), 256'd65);
      chk("next_cycle_start_digest", dg, ref_compress(IV_REF, mb));

      // reset at cycle 40 aborts the hash
      ma = rand_block();
      message = ma;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy",   {255'd0, busy}, 256'd0);
      chk("abort_done",   {255'd0, done}, 256'd0);
      chk("abort_digest", digest, 256'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      chk("abort_no_done", 256'(pulses), 256'd0);
      run_block(ma, dg, lat);
      chk("after_abort_digest",  dg, ref_compress(IV_REF, ma));
      chk("after_abort_latency", 256'(lat), 256'd65);

`ifdef SHA256_CHAIN_EN
      begin
         string        s2;
         logic [511:0] b1, b2;
         logic [255:0] h1;
         s2 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
         b1 = '0;
         for (int i = 0; i < 56; i++) b1[511 - 8*i -: 8] = s2[i];
         b1[511 - 8*56 -: 8] = 8'h80;
         b2 = '0;
         b2[63:0] = 64'd448;
         first = 1'b1;
         run_block(b1, h1, lat);
         chk("chain_block1", h1, ref_compress(IV_REF, b1));
         first = 1'b0;
         run_block(b2, dg, lat);
         chk("chain_block2", dg, 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
         first = 1'b1;
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
